// File: rtl/imem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_responder_if
// Brief    : Fetch read bus and program-load write bus of the instruction memory.
// Revision : 1.0
// ============================================================================
interface imem_responder_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ready;
  logic [63:0]           mem_rdata;
  logic                  mem_rvalid;
  logic                  prog_we;
  logic [ADDR_WIDTH-1:0] prog_addr;
  logic [63:0]           prog_wdata;

  modport master (
    output mem_re, mem_addr, prog_we, prog_addr, prog_wdata,
    input  mem_ready, mem_rdata, mem_rvalid
  );

  modport slave (
    input  mem_re, mem_addr, prog_we, prog_addr, prog_wdata,
    output mem_ready, mem_rdata, mem_rvalid
  );
endinterface
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module   : imem_responder
// Brief    : 64-bit-word instruction memory answering fetch reads after LATENCY cycles.
// Revision : 1.0
// ============================================================================
module imem_responder #(
  parameter int ADDR_WIDTH = 4,
  parameter int LATENCY    = 1
) (
  input logic             clk,
  input logic             rst,
  imem_responder_if.slave bus
);
  localparam int         c_depth     = 2 ** ADDR_WIDTH;
  localparam logic [1:0] c_wait_load = 2'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 4) begin : g_latency_check
    $error("imem_responder: LATENCY must be within 1..4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  logic [63:0] r_mem [c_depth];
  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [63:0] r_hold;
  logic [63:0] r_rdata;
  logic        r_rvalid;
  logic        r_ready;
  logic        w_accept;

  assign w_accept       = bus.mem_re && r_ready;
  assign bus.mem_ready  = r_ready;
  assign bus.mem_rdata  = r_rdata;
  assign bus.mem_rvalid = r_rvalid;

  // Contents survive reset; only program loads are blocked while it is asserted.
  always_ff @(posedge clk) begin
    if (rst && bus.prog_we) begin
      r_mem[bus.prog_addr] <= bus.prog_wdata;
    end
  end

  // The array read here sees the pre-write word, giving read-before-write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 2'd0;
      r_rvalid <= 1'b0;
      r_rdata  <= 64'h0;
      r_ready  <= 1'b1;
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_accept) begin
            r_hold <= r_mem[bus.mem_addr];
            if (LATENCY == 1) begin
              r_state  <= S_RESP;
              r_rvalid <= 1'b1;
              r_rdata  <= r_mem[bus.mem_addr];
              r_ready  <= 1'b1;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= c_wait_load;
              r_ready <= 1'b0;
            end
          end else begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_cnt == 2'd1) begin
            r_state  <= S_RESP;
            r_cnt    <= 2'd0;
            r_rvalid <= 1'b1;
            r_rdata  <= r_hold;
            r_ready  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_responder
// Brief    : Scoreboard bench driving three responders built with LATENCY 1, 3 and 4.
// Revision : 1.0
// ============================================================================
module tb_imem_responder;
  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  logic [2:0]  re;
  logic [3:0]  addr [3];
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [63:0] prog_wdata;
  logic [2:0]  ready;
  logic [2:0]  rvalid;
  logic [63:0] rdata [3];
  int          cyc = 0;
  int          tests = 0;
  int          failed = 0;
  int          lat [3] = '{1, 3, 4};
  logic [63:0] init_words [4] = '{64'hDEADBEEF00000013, 64'h0000806700100093,
                                  64'h00200113003081B3, 64'h00410133005181B3};

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_responder_if #(.ADDR_WIDTH(4)) if0 ();
  imem_responder_if #(.ADDR_WIDTH(4)) if1 ();
  imem_responder_if #(.ADDR_WIDTH(4)) if2 ();

  assign if0.mem_re = re[0];      assign if0.mem_addr = addr[0];
  assign if1.mem_re = re[1];      assign if1.mem_addr = addr[1];
  assign if2.mem_re = re[2];      assign if2.mem_addr = addr[2];
  assign if0.prog_we = prog_we;   assign if0.prog_addr = prog_addr;   assign if0.prog_wdata = prog_wdata;
  assign if1.prog_we = prog_we;   assign if1.prog_addr = prog_addr;   assign if1.prog_wdata = prog_wdata;
  assign if2.prog_we = prog_we;   assign if2.prog_addr = prog_addr;   assign if2.prog_wdata = prog_wdata;
  assign ready  = {if2.mem_ready,  if1.mem_ready,  if0.mem_ready};
  assign rvalid = {if2.mem_rvalid, if1.mem_rvalid, if0.mem_rvalid};
  assign rdata[0] = if0.mem_rdata;
  assign rdata[1] = if1.mem_rdata;
  assign rdata[2] = if2.mem_rdata;

  imem_responder #(.ADDR_WIDTH(4), .LATENCY(1)) dut_l1 (.clk(clk), .rst(rst_n[0]), .bus(if0.slave));
  imem_responder #(.ADDR_WIDTH(4), .LATENCY(3)) dut_l3 (.clk(clk), .rst(rst_n[1]), .bus(if1.slave));
  imem_responder #(.ADDR_WIDTH(4), .LATENCY(4)) dut_l4 (.clk(clk), .rst(rst_n[2]), .bus(if2.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input int k, input logic [63:0] d, input int due);
    exp_t e;
    e.data = d;
    e.due  = due;
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Every rvalid pulse must match the oldest outstanding request of that instance.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rvalid[k] === 1'b1) begin
        exp_t e;
        bit   got;
        got = 1'b0;
        case (k)
          0:       if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
          1:       if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
          default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
        endcase
        tests++;
        if (!got) begin
          failed++;
          $display("FAIL unexpected_rvalid dut%0d cycle %0d rdata=%h (no request pending)", k, cyc, rdata[k]);
        end else if (rdata[k] !== e.data || cyc != e.due) begin
          failed++;
          $display("FAIL response dut%0d got %h at cycle %0d, expected %h at cycle %0d",
                   k, rdata[k], cyc, e.data, e.due);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 3'b000;
    tick();
    tick();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (ready[k] !== 1'b1) begin failed++; $display("FAIL reset_ready dut%0d got %b expected 1", k, ready[k]); end
      tests++;
      if (rvalid[k] !== 1'b0) begin failed++; $display("FAIL reset_rvalid dut%0d got %b expected 0", k, rvalid[k]); end
      tests++;
      if (rdata[k] !== 64'h0) begin failed++; $display("FAIL reset_rdata dut%0d got %h expected 0", k, rdata[k]); end
    end
    tick();
    rst_n = 3'b111;
    tick();
  endtask

  task automatic load_program();
    for (int i = 0; i < 4; i++) begin
      prog_we    = 1'b1;
      prog_addr  = 4'(i);
      prog_wdata = init_words[i];
      tick();
    end
    prog_we = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      re[0]   = 1'b1;
      addr[0] = 4'(i);
      sb_push(0, init_words[i], cyc + 1);
      @(negedge clk);
      tests++;
      if (ready[0] !== 1'b1) begin failed++; $display("FAIL b2b_ready addr %0d got %b expected 1", i, ready[0]); end
      tick();
    end
    re[0] = 1'b0;
    tick();
    tick();
    @(negedge clk);
    tests++;
    if (rdata[0] !== init_words[3] || rvalid[0] !== 1'b0) begin
      failed++;
      $display("FAIL rdata_hold got %h/rvalid %b expected %h/0", rdata[0], rvalid[0], init_words[3]);
    end
    tick();
  endtask

  task automatic test_latency_wait();
    re[1]   = 1'b1;
    addr[1] = 4'd2;
    sb_push(1, init_words[2], cyc + 3);
    tick();
    addr[1] = 4'd0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      tests++;
      if (ready[1] !== 1'b0) begin failed++; $display("FAIL wait_ready step %0d got %b expected 0", j, ready[1]); end
      tick();
    end
    re[1] = 1'b0;
    @(negedge clk);
    tests++;
    if (ready[1] !== 1'b1) begin failed++; $display("FAIL resp_ready got %b expected 1", ready[1]); end
    repeat (4) tick();
  endtask

  task automatic test_read_before_write();
    prog_we    = 1'b1;
    prog_addr  = 4'd1;
    prog_wdata = 64'h0;
    re[0]      = 1'b1;
    addr[0]    = 4'd1;
    sb_push(0, init_words[1], cyc + 1);
    tick();
    prog_we = 1'b0;
    sb_push(0, 64'h0, cyc + 1);
    tick();
    re[0] = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset_inflight();
    re[2]   = 1'b1;
    addr[2] = 4'd3;
    sb_push(2, init_words[3], cyc + 4);
    tick();
    re[2] = 1'b0;
    repeat (4) tick();
    re[2]   = 1'b1;
    addr[2] = 4'd0;
    tick();
    re[2] = 1'b0;
    tick();
    rst_n[2] = 1'b0;
    tick();
    rst_n[2] = 1'b1;
    @(negedge clk);
    tests++;
    if (rdata[2] !== 64'h0) begin failed++; $display("FAIL inflight_rdata got %h expected 0", rdata[2]); end
    tests++;
    if (ready[2] !== 1'b1) begin failed++; $display("FAIL inflight_ready got %b expected 1", ready[2]); end
    tests++;
    if (rvalid[2] !== 1'b0) begin failed++; $display("FAIL inflight_rvalid got %b expected 0", rvalid[2]); end
    repeat (6) tick();
  endtask

  task automatic test_prog_in_reset();
    rst_n      = 3'b000;
    prog_we    = 1'b1;
    prog_addr  = 4'd3;
    prog_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    prog_we = 1'b0;
    rst_n   = 3'b111;
    tick();
    for (int k = 0; k < 3; k++) begin
      re[k]   = 1'b1;
      addr[k] = 4'd3;
      sb_push(k, init_words[3], cyc + lat[k]);
    end
    tick();
    re = 3'b000;
    repeat (6) tick();
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((q0.size() + q1.size() + q2.size()) > 0 && waited < 20) begin
      tick();
      waited++;
    end
    while (q0.size() > 0) begin exp_t e; e = q0.pop_front(); tests++; failed++;
      $display("FAIL missing_response dut0 got none expected %h at cycle %0d", e.data, e.due); end
    while (q1.size() > 0) begin exp_t e; e = q1.pop_front(); tests++; failed++;
      $display("FAIL missing_response dut1 got none expected %h at cycle %0d", e.data, e.due); end
    while (q2.size() > 0) begin exp_t e; e = q2.pop_front(); tests++; failed++;
      $display("FAIL missing_response dut2 got none expected %h at cycle %0d", e.data, e.due); end
  endtask

  initial begin
    rst_n      = 3'b000;
    re         = 3'b000;
    addr[0]    = 4'd0;
    addr[1]    = 4'd0;
    addr[2]    = 4'd0;
    prog_we    = 1'b0;
    prog_addr  = 4'd0;
    prog_wdata = 64'h0;
    test_reset();
    load_program();
    test_back_to_back();
    test_latency_wait();
    test_reset_inflight();
    test_read_before_write();
    test_prog_in_reset();
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, giving the width of the 64-bit-word address; depth is 2**ADDR_WIDTH words.
REQ-002 The block SHALL have parameter LATENCY, default 1, legal range 1..4, giving the cycles from request acceptance to response.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port mem_re, input, 1 bit: read request from fetch.
REQ-006 The block SHALL have port mem_addr, input, ADDR_WIDTH bits: 64-bit-word index of the read.
REQ-007 The block SHALL have port mem_ready, output, 1 bit: the responder can accept a request this cycle.
REQ-008 The block SHALL have port mem_rdata, output, 64 bits: read data; [31:0] is the instruction at the even slot, [63:32] the instruction at the odd slot.
REQ-009 The block SHALL have port mem_rvalid, output, 1 bit: one-cycle pulse marking mem_rdata valid.
REQ-010 The block SHALL have port prog_we, input, 1 bit: program-load write enable.
REQ-011 The block SHALL have port prog_addr, input, ADDR_WIDTH bits: write word index.
REQ-012 The block SHALL have port prog_wdata, input, 64 bits: write data.

Function
REQ-013 Storage SHALL be a 2**ADDR_WIDTH x 64-bit array; the full address range is valid, so no out-of-range case exists.
REQ-014 A read SHALL be accepted on a rising edge where rst=1, mem_re=1 and mem_ready=1; the acceptance cycle is T.
REQ-015 At acceptance, the word at mem_addr SHALL be captured into an internal hold register; later writes do not change a response already in flight.
REQ-016 mem_rvalid SHALL be 1 for exactly cycle T+LATENCY, and mem_rdata SHALL carry the captured word in that cycle.
REQ-017 mem_rdata SHALL hold its last driven value while mem_rvalid=0.
REQ-018 The FSM SHALL have three states: IDLE, WAIT and RESP.
- IDLE: on accept, go to RESP if LATENCY=1, else load the counter with LATENCY-1 and go to WAIT.
- WAIT: decrement the counter; go to RESP when it reaches 1.
- RESP: mem_rvalid=1; on a new accept, go to RESP or WAIT as from IDLE; otherwise go to IDLE.
REQ-019 mem_ready SHALL be 1 in IDLE and RESP and 0 in WAIT; with LATENCY=1, back-to-back requests SHALL give one response per cycle.
REQ-020 mem_re while mem_ready=0 SHALL be ignored: no capture, no state change, no response.
REQ-021 prog_we=1 SHALL write prog_wdata to prog_addr at the rising edge, in any FSM state.
REQ-022 prog_we and an accepted read to the same address in the same cycle SHALL be read-before-write: the response returns the old word, and the new word is visible to later reads.
REQ-023 The wait counter SHALL be 2 bits wide; LATENCY outside 1..4 is illegal and SHALL be flagged by an elaboration-time check.

Reset
REQ-024 While rst=0 at a rising edge: state SHALL go to IDLE, the counter to 0, mem_rvalid to 0, mem_rdata to 64'h0, and mem_ready SHALL read 1 from the following cycle.
REQ-025 A read in flight when reset is applied SHALL be dropped, with no mem_rvalid pulse after reset is released.
REQ-026 Array contents SHALL NOT be cleared by reset; prog_we writes SHALL be ignored while rst=0.

Verification
REQ-027 Load words 0..3 with {DEADBEEF,00000013}, {00008067,00100093}, {00200113,003081B3}, {00410133,005181B3}; LATENCY=1; read addr 0,1,2,3 on consecutive cycles -> mem_rvalid high 4 consecutive cycles, each one cycle after its request, mem_rdata = the four words in order.
REQ-028 LATENCY=3; read addr 2 at T -> mem_ready=0 at T+1 and T+2; mem_rvalid=1 only at T+3 with 64'h00200113003081B3; mem_re held high during WAIT is ignored.
REQ-029 Same-cycle prog_we to addr 1 with 64'h0 and read of addr 1 -> response 64'h0000806700100093; next read of addr 1 returns 64'h0.
REQ-030 LATENCY=4; accept read at T; rst=0 at T+2 for one cycle -> no mem_rvalid at T+4; mem_rdata=0 and mem_ready=1 after reset.
REQ-031 prog_we with rst=0 to addr 3 -> a later read of addr 3 still returns 64'h00410133005181B3; rvalid never asserts without an accepted request.
